// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog escalation controller: FSM state
// encoding and the width of the event statistics counters.
package wdt_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ALERT   = 3'd1,
    S_CLEAR   = 3'd2,
    S_RESET   = 3'd3,
    S_LOCKOUT = 3'd4
  } wdt_state_t;

  localparam int STATS_W = 8;

endpackage

// File: rtl/wdt_esc_timer.sv
// Loadable up-counter with synchronous clear, enable and terminal compare.
// The count holds at TERM, so it never wraps while the enable stays high.
module wdt_esc_timer #(
  parameter int W    = 4,
  parameter int TERM = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] din,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  assign done = (cnt == W'(TERM));

  // Clear dominates load, load dominates count; stop counting at terminal.
  always_ff @(posedge clk) begin
    if (rst || clr)         cnt <= '0;
    else if (ld)            cnt <= din;
    else if (en && !done)   cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/wdt_escalation.sv
// Watchdog escalation controller: alert host, wait for ack within a grace
// window, else pulse a recovery reset; lock the system in reset after
// MAX_RETRIES consecutive unacknowledged expiries.
// Optional feature macro WDT_ESC_STATS_EN adds saturating entry counters
// for ALERT and RESET; without it both stats outputs are tied to zero.
module wdt_escalation
  import wdt_pkg::*;
#(
  parameter int GRACE_CNT     = 1000,
  parameter int RST_PULSE_CNT = 16,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wdt_irq,
  input  logic       host_ack,
  output logic       host_irq,
  output logic       wdt_clr,
  output logic       sys_rst,
  output logic       lockout,
  output logic [7:0] irq_events,
  output logic [7:0] rst_events
);

  localparam int GW = $clog2(GRACE_CNT + 1);
  localparam int PW = $clog2(RST_PULSE_CNT + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  wdt_state_t    state;
  logic [RW-1:0] retry;
  logic          grace_done;
  logic          pulse_done;

  // Grace window: held at 0 outside ALERT, so the first ALERT cycle reads 0.
  wdt_esc_timer #(.W(GW), .TERM(GRACE_CNT - 1)) u_grace (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != S_ALERT),
    .ld   (1'b0),
    .din  ({GW{1'b0}}),
    .en   (state == S_ALERT),
    .done (grace_done)
  );

  // Reset pulse length: same scheme, active only in RESET.
  wdt_esc_timer #(.W(PW), .TERM(RST_PULSE_CNT - 1)) u_pulse (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != S_RESET),
    .ld   (1'b0),
    .din  ({PW{1'b0}}),
    .en   (state == S_RESET),
    .done (pulse_done)
  );

  // Escalation FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      retry    <= '0;
      host_irq <= 1'b0;
      wdt_clr  <= 1'b0;
      sys_rst  <= 1'b0;
      lockout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wdt_irq) begin
            state    <= S_ALERT;
            host_irq <= 1'b1;
          end
        end
        S_ALERT: begin
          // Ack is checked first so it wins over a simultaneous timeout.
          if (host_ack) begin
            state    <= S_CLEAR;
            host_irq <= 1'b0;
            wdt_clr  <= 1'b1;
            retry    <= '0;
          end else if (grace_done) begin
            state    <= S_RESET;
            host_irq <= 1'b0;
            wdt_clr  <= 1'b1;
            sys_rst  <= 1'b1;
            retry    <= retry + RW'(1);
          end
        end
        S_CLEAR: begin
          state   <= S_IDLE;
          wdt_clr <= 1'b0;
        end
        S_RESET: begin
          if (pulse_done) begin
            if (retry == RW'(MAX_RETRIES)) begin
              state   <= S_LOCKOUT;
              lockout <= 1'b1;
            end else begin
              state   <= S_IDLE;
              wdt_clr <= 1'b0;
              sys_rst <= 1'b0;
            end
          end
        end
        S_LOCKOUT: begin
          state <= S_LOCKOUT;
        end
        default: begin
          state    <= S_IDLE;
          host_irq <= 1'b0;
          wdt_clr  <= 1'b0;
          sys_rst  <= 1'b0;
          lockout  <= 1'b0;
        end
      endcase
    end
  end

`ifdef WDT_ESC_STATS_EN
  wdt_state_t         st_q;
  logic [STATS_W-1:0] irq_cnt;
  logic [STATS_W-1:0] rst_cnt;

  // Count state entries (current state differs from last cycle's), saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= S_IDLE;
      irq_cnt <= '0;
      rst_cnt <= '0;
    end else begin
      st_q <= state;
      if (state == S_ALERT && st_q != S_ALERT && irq_cnt != '1)
        irq_cnt <= irq_cnt + STATS_W'(1);
      if (state == S_RESET && st_q != S_RESET && rst_cnt != '1)
        rst_cnt <= rst_cnt + STATS_W'(1);
    end
  end

  assign irq_events = irq_cnt;
  assign rst_events = rst_cnt;
`else
  assign irq_events = '0;
  assign rst_events = '0;
`endif

endmodule
